// File: rtl/queue_seq_scheduler_if.sv
// Handshake bundle between the sample queues, the shared FIR MAC and the
// queue sequencing scheduler. The scheduler takes the slave side; whoever
// raises the per-queue requests takes the master side.
interface queue_seq_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] seq_en;
  logic [ADDR_W-1:0]  coef_addr;
  logic               mac_clr;
  logic               mac_en;
  logic               result_vld;
  logic [ID_W-1:0]    result_id;
  logic               busy;
  logic               ovr;

  modport master (
    output req,
    input  seq_en, coef_addr, mac_clr, mac_en, result_vld, result_id, busy, ovr
  );

  modport slave (
    input  req,
    output seq_en, coef_addr, mac_clr, mac_en, result_vld, result_id, busy, ovr
  );
endinterface

// File: rtl/queue_seq_scheduler.sv
// Round-robin scheduler that runs one TAPS-long read burst at a time through
// a shared FIR MAC. Requests are latched as pending bits, granted in
// round-robin order after the last served queue, and each burst walks
// SETUP (accumulator clear), RUN (queue advance + coefficient address),
// DRAIN (read-latency flush) and DONE (result strobe).
module queue_seq_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TAPS    = 1021,
  parameter int ADDR_W  = 10,
  parameter int RD_LAT  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  queue_seq_scheduler_if.slave  bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int DRN_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t             state;
  logic [NUM_REQ-1:0] pend;
  logic [NUM_REQ-1:0] clr;
  logic [ID_W-1:0]    rr_last;
  logic [ID_W-1:0]    grant_id;
  logic               grant_vld;
  logic [ADDR_W-1:0]  tap_cnt;
  logic [DRN_W-1:0]   drain_cnt;
  logic [RD_LAT-1:0]  run_pipe;

  logic [NUM_REQ-1:0] seq_en;
  logic [ADDR_W-1:0]  coef_addr;
  logic               mac_clr;
  logic               result_vld;
  logic [ID_W-1:0]    result_id;
  logic               busy;
  logic               ovr;

  // Returns {found, id}: first pending queue scanning last+1, last+2, ...
  // modulo NUM_REQ. The scan runs farthest-first so the nearest hit wins.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] p,
                                            input logic [ID_W-1:0]    last);
    logic [ID_W:0]   r;
    logic [ID_W-1:0] sel;
    int              idx;
    // NOTE: every variable gets a value before any conditional assignment,
    // so the combinational result never depends on a previous evaluation
    // (no inferred latch when this is used from continuous logic).
    r   = '0;
    sel = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      sel = ID_W'(idx);
      if (p[sel]) r = {1'b1, sel};
    end
    return r;
  endfunction

  assign {grant_vld, grant_id} = rr_pick(pend, rr_last);

  // A pending bit is cleared only at the edge where that queue is granted.
  assign clr = (state == IDLE && grant_vld) ? (NUM_REQ'(1) << grant_id) : '0;

  // Burst sequencer plus pending-request bookkeeping; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pend       <= '0;
      rr_last    <= ID_W'(NUM_REQ - 1);
      tap_cnt    <= '0;
      drain_cnt  <= '0;
      seq_en     <= '0;
      coef_addr  <= '0;
      mac_clr    <= 1'b0;
      result_vld <= 1'b0;
      result_id  <= '0;
      busy       <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // sees the pre-edge value (e.g. pend and clr below use the old pend).
      // A new request always wins over a same-cycle clear; a repeat request
      // on an already pending queue merges and flags an overrun.
      pend    <= (pend & ~clr) | bus.req;
      ovr     <= |(bus.req & pend & ~clr);
      mac_clr    <= 1'b0;
      result_vld <= 1'b0;

      unique case (state)
        IDLE: begin
          if (grant_vld) begin
            state     <= SETUP;
            result_id <= grant_id;
            mac_clr   <= 1'b1;
            busy      <= 1'b1;
          end
        end

        SETUP: begin
          state     <= RUN;
          tap_cnt   <= '0;
          coef_addr <= '0;
          seq_en    <= NUM_REQ'(1) << result_id;
        end

        RUN: begin
          if (tap_cnt == ADDR_W'(TAPS - 1)) begin
            state     <= DRAIN;
            drain_cnt <= '0;
            tap_cnt   <= '0;
            coef_addr <= '0;
            seq_en    <= '0;
          end else begin
            tap_cnt   <= tap_cnt + 1'b1;
            coef_addr <= tap_cnt + 1'b1;
          end
        end

        DRAIN: begin
          if (drain_cnt == DRN_W'(RD_LAT - 1)) begin
            state      <= DONE;
            result_vld <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end

        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          rr_last <= result_id;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // RUN indicator delayed by RD_LAT flops so mac_en lines up with read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_pipe <= '0;
    end else begin
      run_pipe <= RD_LAT'({run_pipe, |seq_en});
    end
  end

  assign bus.seq_en     = seq_en;
  assign bus.coef_addr  = coef_addr;
  assign bus.mac_clr    = mac_clr;
  assign bus.mac_en     = run_pipe[RD_LAT-1];
  assign bus.result_vld = result_vld;
  assign bus.result_id  = result_id;
  assign bus.busy       = busy;
  assign bus.ovr        = ovr;

endmodule

// File: tb/tb_queue_seq_scheduler.sv
// Self-checking bench for queue_seq_scheduler. A burst-timeline reference
// model (grant edge + offset arithmetic, pending set, round-robin scan)
// predicts every output each cycle; directed steps cover the documented
// scenarios and a randomized phase exercises arbitrary request mixes.
module tb_queue_seq_scheduler;
  localparam int NUM_REQ = 4;
  localparam int TAPS    = 8;
  localparam int ADDR_W  = 10;
  localparam int RD_LAT  = 1;
  localparam int BURST   = TAPS + RD_LAT + 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  queue_seq_scheduler_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)) bus ();

  queue_seq_scheduler #(
    .NUM_REQ(NUM_REQ),
    .TAPS   (TAPS),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  int                 cyc = 0;
  int                 m_g = 0;
  int                 m_id = 0;
  int                 m_rr = NUM_REQ - 1;
  bit                 m_active = 1'b0;
  bit                 m_ovr = 1'b0;
  logic [NUM_REQ-1:0] m_pend = '0;
  int                 grants[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock edge of the reference model with the inputs sampled there.
  task automatic model_edge(input bit rst_v, input logic [NUM_REQ-1:0] req_v);
    logic [NUM_REQ-1:0] clr;
    bit found;
    int q;
    cyc++;
    clr   = '0;
    m_ovr = 1'b0;
    if (rst_v) begin
      m_pend   = '0;
      m_rr     = NUM_REQ - 1;
      m_active = 1'b0;
      m_id     = 0;
    end else begin
      if (m_active) begin
        if (cyc - m_g == BURST - 1) begin
          m_active = 1'b0;
          m_rr     = m_id;
        end
      end else if (m_pend != '0) begin
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
          q = (m_rr + k) % NUM_REQ;
          if (!found && m_pend[q]) begin
            found = 1'b1;
            m_id  = q;
          end
        end
        clr[m_id] = 1'b1;
        m_g       = cyc;
        m_active  = 1'b1;
      end
      m_ovr  = |(req_v & m_pend & ~clr);
      m_pend = (m_pend & ~clr) | req_v;
    end
  endtask

  task automatic compare_all();
    int                 off;
    logic [NUM_REQ-1:0] e_seq;
    int                 e_addr;
    bit                 e_clr, e_en, e_vld, e_busy;
    off    = cyc - m_g;
    e_seq  = '0;
    e_addr = 0;
    e_clr  = 1'b0;
    e_en   = 1'b0;
    e_vld  = 1'b0;
    e_busy = 1'b0;
    if (m_active) begin
      e_busy = 1'b1;
      e_clr  = (off == 0);
      if (off >= 1 && off <= TAPS) begin
        e_seq  = NUM_REQ'(1) << m_id;
        e_addr = off - 1;
      end
      e_en  = (off >= 1 + RD_LAT) && (off <= TAPS + RD_LAT);
      e_vld = (off == TAPS + RD_LAT + 1);
    end
    check("seq_en",     bus.seq_en,     e_seq);
    check("coef_addr",  bus.coef_addr,  e_addr);
    check("mac_clr",    bus.mac_clr,    e_clr);
    check("mac_en",     bus.mac_en,     e_en);
    check("result_vld", bus.result_vld, e_vld);
    check("result_id",  bus.result_id,  m_id);
    check("busy",       bus.busy,       e_busy);
    check("ovr",        bus.ovr,        m_ovr);
  endtask

  task automatic step(input bit rst_v, input logic [NUM_REQ-1:0] req_v);
    rst     = rst_v;
    bus.req = req_v;
    @(posedge clk);
    model_edge(rst_v, req_v);
    #1;
    compare_all();
    if (bus.mac_clr) grants.push_back(int'(bus.result_id));
    rst     = 1'b0;
    bus.req = '0;
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int n;
    n = 0;
    while ((m_active || m_pend != '0) && n < max_cycles) begin
      step(1'b0, '0);
      n++;
    end
    check(tag, (m_active || m_pend != '0), 1'b0);
  endtask

  initial begin
    int  e0, clr_at, vld_at, en_first, seq_n, en_n, busy_n, run_n;
    bit  hit;
    logic [31:0] r;
    logic [NUM_REQ-1:0] rq;

    rst     = 1'b1;
    bus.req = '0;

    // Reset state
    step(1'b1, '0);
    step(1'b1, '0);

    // Single request on queue 0; cycle numbers counted from the req edge
    step(1'b0, 4'b0001);
    e0 = cyc;
    clr_at = -1; vld_at = -1; en_first = -1;
    seq_n = 0; en_n = 0; busy_n = 0;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, '0);
      if (bus.mac_clr && clr_at < 0) clr_at = cyc - e0 + 1;
      if (bus.result_vld && vld_at < 0) vld_at = cyc - e0 + 1;
      if (bus.mac_en && en_first < 0) en_first = cyc - e0 + 1;
      if (bus.seq_en == 4'b0001) seq_n++;
      if (bus.mac_en) en_n++;
      if (bus.busy) busy_n++;
    end
    check("single_mac_clr_cycle", clr_at, 2);
    check("single_result_vld_cycle", vld_at, 12);
    check("single_mac_en_first", en_first, 4);
    check("single_seq_en_count", seq_n, 8);
    check("single_mac_en_count", en_n, 8);
    check("single_busy_count", busy_n, 11);

    // Round-robin order from a fresh reset
    step(1'b1, '0);
    grants.delete();
    step(1'b0, 4'b1111);
    drain("rr_all_drain", 200);
    check("rr_all_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) check("rr_all_order", grants[i], i);
    grants.delete();
    step(1'b0, 4'b1001);
    drain("rr_pair_drain", 100);
    check("rr_pair_count", grants.size(), 2);
    if (grants.size() == 2) begin
      check("rr_pair_first", grants[0], 0);
      check("rr_pair_second", grants[1], 3);
    end

    // Overrun: queue 2 requests twice while queue 0 is being served
    grants.delete();
    step(1'b0, 4'b0001);
    step(1'b0, '0);
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0100);
    check("ovr_pulse", bus.ovr, 1'b1);
    step(1'b0, '0);
    check("ovr_single_cycle", bus.ovr, 1'b0);
    drain("ovr_drain", 100);
    check("ovr_grant_count", grants.size(), 2);
    if (grants.size() == 2) check("ovr_second_is_q2", grants[1], 2);

    // Self re-request during queue 1's RUN
    grants.delete();
    step(1'b0, 4'b0010);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step(1'b0, '0);
      if (bus.seq_en[1]) hit = 1'b1;
    end
    check("self_reach_run", hit, 1'b1);
    step(1'b0, 4'b0010);
    check("self_no_ovr", bus.ovr, 1'b0);
    drain("self_drain", 100);
    check("self_grant_count", grants.size(), 2);
    if (grants.size() == 2) check("self_regrant_q1", grants[1], 1);

    // Reset in the 6th RUN cycle of a burst
    grants.delete();
    step(1'b0, 4'b0100);
    run_n = 0;
    for (int i = 0; i < 20 && run_n < 6; i++) begin
      step(1'b0, '0);
      if (bus.seq_en != '0) run_n++;
    end
    check("rst_mid_reach_run6", run_n, 6);
    step(1'b1, '0);
    check("rst_mid_outputs",
          {bus.seq_en, bus.coef_addr, bus.mac_clr, bus.mac_en, bus.result_vld,
           bus.result_id, bus.busy, bus.ovr}, '0);
    grants.delete();
    step(1'b0, 4'b1001);
    hit = 1'b0;
    for (int i = 0; i < 3 * BURST; i++) begin
      step(1'b0, '0);
      if (bus.result_vld) hit = 1'b1;
      if (!m_active && m_pend == '0) break;
    end
    check("rst_mid_post_vld", hit, 1'b1);
    check("rst_mid_grant_count", grants.size(), 2);
    if (grants.size() == 2) begin
      check("rst_mid_first_q0", grants[0], 0);
      check("rst_mid_second_q3", grants[1], 3);
    end

    // Randomized requests with occasional resets
    for (int i = 0; i < 1500; i++) begin
      r = $urandom;
      for (int b = 0; b < NUM_REQ; b++) rq[b] = (r[4*b +: 4] == 4'd0);
      step(($urandom_range(0, 499) == 0), rq);
    end
    drain("random_drain", 20 * BURST);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
